// File: rtl/tile_pixel_pipe.sv
// ---------------------------------------------------------------------------
// tile_pixel_pipe
//   Pixel stage behind the VGA sync generator. Turns hcnt/vcnt plus the
//   sync/enable strobes into one 8-bit RRRGGGBB pixel per clock:
//     - looks up the background tile index in the external map RAM,
//     - fetches the tile pixel from the external tile ROM,
//     - overlays a single 16x16 player sprite (pixel value 0 = transparent),
//     - delays hsync/vsync so they stay aligned with rgb,
//     - pulses frame_tick once per frame at the start of vertical blank.
//   Fixed 5-cycle latency, one pixel per clock, no stalls.
//
// Ports
//   clk25m      in   pixel clock, all logic on posedge
//   rst_n       in   synchronous reset, active low
//   hcnt/vcnt   in   horizontal / vertical counters
//   hsync_in    in   hsync from the sync generator (active low)
//   vsync_in    in   vsync from the sync generator (active low)
//   henable     in   horizontal display enable
//   venable     in   vertical display enable
//   player_x/y  in   sprite top-left corner, latched once per frame
//   map_addr    out  map RAM address (row*MAP_COLS + col)
//   map_data    in   map RAM data, 1-cycle read latency
//   tile_addr   out  tile ROM address {idx, py, px}
//   tile_data   in   tile ROM data, 1-cycle read latency
//   spr_addr    out  sprite ROM address {sy, sx}
//   spr_data    in   sprite ROM data, 1-cycle read latency
//   rgb         out  pixel to the DAC
//   hsync_out   out  hsync delayed to match rgb
//   vsync_out   out  vsync delayed to match rgb
//   frame_tick  out  1-cycle pulse at start of vertical blank
// ---------------------------------------------------------------------------
module tile_pixel_pipe #(
   parameter int TILE_LOG2 = 4,
   parameter int MAP_COLS  = 40,
   parameter int MAP_ROWS  = 30,
   parameter int HACT      = 640,
   parameter int VACT      = 480,
   parameter int IDX_W     = 6,
   parameter int PIX_W     = 8
) (
   input  logic                         clk25m,
   input  logic                         rst_n,
   input  logic [9:0]                   hcnt,
   input  logic [9:0]                   vcnt,
   input  logic                         hsync_in,
   input  logic                         vsync_in,
   input  logic                         henable,
   input  logic                         venable,
   input  logic [9:0]                   player_x,
   input  logic [9:0]                   player_y,
   output logic [10:0]                  map_addr,
   input  logic [IDX_W-1:0]             map_data,
   output logic [IDX_W+2*TILE_LOG2-1:0] tile_addr,
   input  logic [PIX_W-1:0]             tile_data,
   output logic [2*TILE_LOG2-1:0]       spr_addr,
   input  logic [PIX_W-1:0]             spr_data,
   output logic [PIX_W-1:0]             rgb,
   output logic                         hsync_out,
   output logic                         vsync_out,
   output logic                         frame_tick
);

   localparam int MAP_LAST = MAP_ROWS * MAP_COLS - 1;

   logic        active_in;
   logic        frame_start;
   logic [19:0] maddr_full;

   logic [9:0]  h_p1, v_p1, h_p2, v_p2;
   logic        hs_p1, hs_p2, hs_p3, hs_p4;
   logic        vs_p1, vs_p2, vs_p3, vs_p4;
   logic        vld_p1, vld_p2, vld_p3, vld_p4;
   logic        hit_p3, hit_p4;

   logic [9:0]  px_l, py_l;
   logic [10:0] dx_w, dy_w;
   logic        hit_w;

   function automatic logic [PIX_W-1:0] pick_pixel(input logic             vld,
                                                   input logic             hit,
                                                   input logic [PIX_W-1:0] spr,
                                                   input logic [PIX_W-1:0] tile);
      if (!vld)
         return '0;
      if (hit && (spr != '0))
         return spr;
      return tile;
   endfunction

   assign active_in   = henable && venable && (hcnt < 10'(HACT)) && (vcnt < 10'(VACT));
   assign frame_start = (hcnt == 10'd0) && (vcnt == 10'(VACT));
   assign maddr_full  = 20'(vcnt >> TILE_LOG2) * 20'(MAP_COLS) + 20'(hcnt >> TILE_LOG2);

   // One extra bit so that a pixel left of / above the sprite borrows
   // and is rejected instead of wrapping into the sprite window.
   assign dx_w  = {1'b0, h_p2} - {1'b0, px_l};
   assign dy_w  = {1'b0, v_p2} - {1'b0, py_l};
   assign hit_w = !dx_w[10] && (dx_w[9:TILE_LOG2] == '0) &&
                  !dy_w[10] && (dy_w[9:TILE_LOG2] == '0);

   always_ff @(posedge clk25m) begin
      if (!rst_n) begin
         h_p1 <= '0;  v_p1 <= '0;  hs_p1 <= 1'b1;  vs_p1 <= 1'b1;  vld_p1 <= 1'b0;
         map_addr   <= '0;
         frame_tick <= 1'b0;
         px_l <= '0;  py_l <= '0;
         h_p2 <= '0;  v_p2 <= '0;  hs_p2 <= 1'b1;  vs_p2 <= 1'b1;  vld_p2 <= 1'b0;
         tile_addr <= '0;  spr_addr <= '0;
         hs_p3 <= 1'b1;  vs_p3 <= 1'b1;  vld_p3 <= 1'b0;  hit_p3 <= 1'b0;
         hs_p4 <= 1'b1;  vs_p4 <= 1'b1;  vld_p4 <= 1'b0;  hit_p4 <= 1'b0;
         rgb <= '0;  hsync_out <= 1'b1;  vsync_out <= 1'b1;
      end else begin
         // ---- p1: capture counters, issue map RAM read, frame latch ----
         h_p1   <= hcnt;
         v_p1   <= vcnt;
         hs_p1  <= hsync_in;
         vs_p1  <= vsync_in;
         vld_p1 <= active_in;
         map_addr <= (active_in && (maddr_full <= 20'(MAP_LAST))) ? maddr_full[10:0] : '0;
         frame_tick <= frame_start;
         if (frame_start) begin
            px_l <= player_x;
            py_l <= player_y;
         end
         // ---- p2: map RAM registers map_data ----
         h_p2   <= h_p1;
         v_p2   <= v_p1;
         hs_p2  <= hs_p1;
         vs_p2  <= vs_p1;
         vld_p2 <= vld_p1;
         // ---- p3: tile and sprite ROM addresses ----
         tile_addr <= {map_data, v_p2[TILE_LOG2-1:0], h_p2[TILE_LOG2-1:0]};
         spr_addr  <= hit_w ? {dy_w[TILE_LOG2-1:0], dx_w[TILE_LOG2-1:0]} : '0;
         hit_p3 <= hit_w;
         hs_p3  <= hs_p2;
         vs_p3  <= vs_p2;
         vld_p3 <= vld_p2;
         // ---- p4: ROMs register tile_data / spr_data ----
         hit_p4 <= hit_p3;
         hs_p4  <= hs_p3;
         vs_p4  <= vs_p3;
         vld_p4 <= vld_p3;
         // ---- p5: sprite-over-tile merge, outputs ----
         rgb       <= pick_pixel(vld_p4, hit_p4, spr_data, tile_data);
         hsync_out <= hs_p4;
         vsync_out <= vs_p4;
      end
   end

endmodule

// File: tb/tb_tile_pixel_pipe.sv
module tb_tile_pixel_pipe;

   localparam int HACT     = 640;
   localparam int VACT     = 480;
   localparam int MAP_COLS = 40;

   logic        clk25m = 1'b0;
   logic        rst_n;
   logic [9:0]  hcnt, vcnt;
   logic        hsync_in, vsync_in, henable, venable;
   logic [9:0]  player_x, player_y;
   logic [10:0] map_addr;
   logic [5:0]  map_data;
   logic [13:0] tile_addr;
   logic [7:0]  tile_data;
   logic [7:0]  spr_addr;
   logic [7:0]  spr_data;
   logic [7:0]  rgb;
   logic        hsync_out, vsync_out, frame_tick;

   always #20 clk25m = ~clk25m;

   tile_pixel_pipe dut (
      .clk25m(clk25m), .rst_n(rst_n), .hcnt(hcnt), .vcnt(vcnt),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .henable(henable), .venable(venable),
      .player_x(player_x), .player_y(player_y),
      .map_addr(map_addr), .map_data(map_data),
      .tile_addr(tile_addr), .tile_data(tile_data),
      .spr_addr(spr_addr), .spr_data(spr_data),
      .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_tick(frame_tick)
   );

   // External memories: map RAM, tile ROM, sprite ROM, all 1-cycle read
   logic [5:0] map_mem  [0:2047];
   logic [7:0] tile_mem [0:16383];
   logic [7:0] spr_mem  [0:255];

   always @(posedge clk25m) begin
      map_data  <= map_mem[map_addr];
      tile_data <= tile_mem[tile_addr];
      spr_data  <= spr_mem[spr_addr];
   end

   // Edge bookkeeping: cyc = number of posedges so far, rst_hist[n] = reset seen at edge n
   int cyc = 0;
   bit rst_hist [0:8191];
   always @(posedge clk25m) begin
      rst_hist[cyc+1] <= !rst_n;
      cyc <= cyc + 1;
   end

   typedef struct { int due; logic [10:0] ma; logic tick; } e1_t;
   typedef struct { int due; int s; logic [13:0] ta; logic [7:0] sa; } e3_t;
   typedef struct { int due; int s; logic [7:0] rgb; logic hs; logic vs; } e5_t;
   e1_t q1[$];
   e3_t q3[$];
   e5_t q5[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference sprite position as latched by the frame rule
   int mpx = 0;
   int mpy = 0;

   function automatic bit rst_between(input int a, input int b);
      for (int e = a; e <= b; e++)
         if (rst_hist[e]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: pops every expectation whose output edge has been reached
   always @(negedge clk25m) begin
      e1_t a;
      e3_t b;
      e5_t c;
      while (q1.size() > 0 && q1[0].due <= cyc) begin
         a = q1.pop_front();
         chk("map_addr", 32'(map_addr), 32'(a.ma));
         chk("frame_tick", 32'(frame_tick), 32'(a.tick));
      end
      while (q3.size() > 0 && q3[0].due <= cyc) begin
         b = q3.pop_front();
         if (!rst_between(b.s, b.due)) begin
            chk("tile_addr", 32'(tile_addr), 32'(b.ta));
            chk("spr_addr", 32'(spr_addr), 32'(b.sa));
         end
      end
      while (q5.size() > 0 && q5[0].due <= cyc) begin
         c = q5.pop_front();
         if (rst_between(c.s, c.due)) begin
            chk("rgb_rst", 32'(rgb), 32'h0);
            chk("hsync_rst", 32'(hsync_out), 32'h1);
            chk("vsync_rst", 32'(vsync_out), 32'h1);
         end else begin
            chk("rgb", 32'(rgb), 32'(c.rgb));
            chk("hsync_out", 32'(hsync_out), 32'(c.hs));
            chk("vsync_out", 32'(vsync_out), 32'(c.vs));
         end
      end
   end

   // Drive one pixel for one clock and push the expected responses
   task automatic step(input logic [9:0] h, input logic [9:0] v,
                       input logic hs, input logic vs, input logic he, input logic ve);
      int  s, hi, vi, idx, dxi, dyi;
      bit  act, hit;
      logic [7:0] tp, sp;
      e1_t a;
      e3_t b;
      e5_t c;
      hcnt = h; vcnt = v; hsync_in = hs; vsync_in = vs; henable = he; venable = ve;
      s  = cyc + 1;
      hi = int'(h);
      vi = int'(v);
      act = he && ve && (hi < HACT) && (vi < VACT);

      a.due  = s;
      a.ma   = (act && rst_n) ? 11'((vi / 16) * MAP_COLS + hi / 16) : 11'd0;
      a.tick = rst_n && (hi == 0) && (vi == VACT);
      q1.push_back(a);

      idx = int'(map_mem[a.ma]);
      dxi = hi - mpx;
      dyi = vi - mpy;
      hit = (dxi >= 0) && (dxi < 16) && (dyi >= 0) && (dyi < 16);
      tp  = tile_mem[idx * 256 + (vi % 16) * 16 + hi % 16];
      sp  = hit ? spr_mem[dyi * 16 + dxi] : 8'h00;

      b.due = s + 2;
      b.s   = s;
      b.ta  = 14'(idx * 256 + (vi % 16) * 16 + hi % 16);
      b.sa  = hit ? 8'(dyi * 16 + dxi) : 8'h00;
      q3.push_back(b);

      c.due = s + 4;
      c.s   = s;
      c.rgb = !act ? 8'h00 : ((sp != 8'h00) ? sp : tp);
      c.hs  = hs;
      c.vs  = vs;
      q5.push_back(c);

      if (!rst_n) begin
         mpx = 0;
         mpy = 0;
      end else if (hi == 0 && vi == VACT) begin
         mpx = int'(player_x);
         mpy = int'(player_y);
      end
      @(posedge clk25m);
      #1;
   endtask

   // Start of vertical blank with a new sprite position; preceded by blanked pixels
   task automatic latch(input int x, input int y);
      player_x = 10'(x);
      player_y = 10'(y);
      step(10'd700, 10'd479, 1'b1, 1'b1, 1'b1, 1'b1);
      step(10'd799, 10'd479, 1'b1, 1'b1, 1'b1, 1'b1);
      step(10'd0, 10'(VACT), 1'b1, 1'b0, 1'b1, 1'b1);
      player_x = 10'($urandom);
      player_y = 10'($urandom);
   endtask

   task automatic rand_step();
      int m;
      logic [9:0] h, v;
      logic he, ve;
      logic [9:0] bh [0:5];
      logic [9:0] bv [0:4];
      bh = '{10'd638, 10'd639, 10'd640, 10'd641, 10'd0, 10'd1023};
      bv = '{10'd478, 10'd479, 10'd480, 10'd481, 10'd0};
      m  = int'($urandom_range(0, 3));
      he = ($urandom_range(0, 9) != 0);
      ve = ($urandom_range(0, 9) != 0);
      case (m)
         0: begin
            h  = 10'($urandom);
            v  = 10'($urandom);
            he = 1'($urandom_range(0, 1));
         end
         1: begin
            h = 10'($urandom_range(0, HACT - 1));
            v = 10'($urandom_range(0, VACT - 1));
         end
         2: begin
            h = 10'(mpx + int'($urandom_range(0, 17)) - 1);
            v = 10'(mpy + int'($urandom_range(0, 17)) - 1);
         end
         default: begin
            h = bh[$urandom_range(0, 5)];
            v = bv[$urandom_range(0, 4)];
         end
      endcase
      if (h == 10'd0 && v == 10'(VACT)) h = 10'd1;
      player_x = 10'($urandom);
      player_y = 10'($urandom);
      step(h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), he, ve);
   endtask

   initial begin
      int left;
      int px_list [0:5];
      int py_list [0:5];
      px_list = '{100, 630, 0, 1020, 300, 500};
      py_list = '{50, 200, 0, 470, 470, 100};

      for (int i = 0; i < 2048; i++)  map_mem[i]  = 6'($urandom);
      for (int i = 0; i < 16384; i++) tile_mem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++)   spr_mem[i]  = ($urandom_range(0, 9) < 3) ? 8'h00 : 8'($urandom_range(1, 255));
      map_mem[42] = 6'd5;
      tile_mem[5 * 256 + 7 * 16 + 3] = 8'hE0;
      spr_mem[0] = 8'h1C;
      spr_mem[1] = 8'h00;

      player_x = '0;
      player_y = '0;

      // Reset with counters running
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) rand_step();
      rst_n = 1'b1;

      // Map cell (2,1) -> idx 5, tile pixel (3,7) = 0xE0
      step(10'd35, 10'd23, 1'b1, 1'b1, 1'b1, 1'b1);

      // Horizontal sync pulse across a line tail
      for (int h = 600; h < 800; h++)
         step(10'(h), 10'd100, !(h >= 656 && h <= 751), 1'b1, (h < HACT), 1'b1);
      // Vertical sync pulse over the blank lines
      for (int v = 485; v < 525; v++)
         step(10'd5, 10'(v), 1'b1, !(v >= 490 && v <= 491), 1'b0, 1'b0);

      // Sprite at (100,50): opaque (0,0), transparent (1,0), neighbours
      latch(100, 50);
      step(10'd100, 10'd50, 1'b1, 1'b1, 1'b1, 1'b1);
      step(10'd101, 10'd50, 1'b1, 1'b1, 1'b1, 1'b1);
      step(10'd99,  10'd50, 1'b1, 1'b1, 1'b1, 1'b1);
      step(10'd116, 10'd50, 1'b1, 1'b1, 1'b1, 1'b1);

      // Sprite at x=630 clipped at the right edge; out-of-range counters
      latch(630, 200);
      for (int h = 628; h < 648; h++)
         step(10'(h), 10'd205, 1'b1, 1'b1, 1'b1, 1'b1);
      step(10'd640, 10'd100, 1'b1, 1'b1, 1'b1, 1'b1);
      step(10'd100, 10'd480, 1'b1, 1'b1, 1'b1, 1'b1);

      // Randomized frames, position changes between latches, one mid-run reset
      for (int r = 0; r < 6; r++) begin
         latch(px_list[r], py_list[r]);
         for (int i = 0; i < 250; i++) begin
            if (r == 3 && i == 100) rst_n = 1'b0;
            if (r == 3 && i == 102) rst_n = 1'b1;
            rand_step();
         end
      end

      // Drain the pipeline
      repeat (8) @(posedge clk25m);
      #1;
      @(negedge clk25m);
      #1;
      left = q1.size() + q3.size() + q5.size();
      n_tests++;
      if (left != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", left);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
